audio_sample_prefetch_cache: RTL and testbench
==============================================

Name: audio_sample_prefetch_cache

Overview:
- Small fully-associative read cache between the audio system's AXI-Lite read master and the shared memory read port.
- Each 32-bit word holds two 16-bit samples, and each channel walks its sample memory sequentially. A channel therefore re-reads the same word on alternate samples.
- Caching the last words fetched roughly halves memory traffic and shortens the per-sample load time within a 32 kHz frame.

Parameters:
- ENTRIES, 8, number of cached words; power of two, minimum 2 (one per channel by default).
- PTR_W, $clog2(ENTRIES), width of the replacement pointer; derived, do not override.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  one-cycle pulse; invalidates all entries (CPU rewrote sample memory).
- s_axil_araddr  input  32  read address from the audio system.
- s_axil_arvalid  input  1  read address valid.
- s_axil_arready  output  1  ready for a read address.
- s_axil_rdata  output  32  full aligned word.
- s_axil_rvalid  output  1  read data valid.
- s_axil_rready  input  1  consumer ready for read data.
- m_axil_araddr  output  32  word-aligned memory address.
- m_axil_arvalid  output  1  memory read address valid.
- m_axil_arready  input  1  memory ready for the address.
- m_axil_rdata  input  32  memory read data.
- m_axil_rvalid  input  1  memory read data valid.
- m_axil_rready  output  1  ready for memory read data.
- hit_count  output  16  saturating count of hits.
- miss_count  output  16  saturating count of misses.

Behaviour:
- Storage per entry: valid bit, tag = addr[31:2], 32-bit data. Replacement is round-robin via a PTR_W-bit pointer that wraps from ENTRIES-1 to 0.
- States: IDLE, FETCH_ADDR, FETCH_DATA, RESPOND. Only one transaction is outstanding at a time.
- IDLE:
  - s_axil_arready=1.
  - On an AR handshake, compare s_axil_araddr[31:2] against all valid tags in the same cycle.
  - Hit: latch the entry data, go to RESPOND, increment hit_count. s_axil_rvalid is high on the next cycle (1-cycle latency).
  - Miss: latch the address, go to FETCH_ADDR, increment miss_count.
- FETCH_ADDR:
  - m_axil_arvalid=1, m_axil_araddr={addr[31:2],2'b00}.
  - Address and valid stay stable until m_axil_arready, then go to FETCH_DATA.
- FETCH_DATA:
  - m_axil_rready=1.
  - On m_axil_rvalid: write tag and data into the entry at the pointer, set valid, advance the pointer, latch the data, go to RESPOND.
- RESPOND:
  - s_axil_rvalid=1, s_axil_rdata stable until s_axil_rready, then go to IDLE.
  - s_axil_arready=0 in every non-IDLE state.
- Low address bits: s_axil_araddr[1:0] are ignored for lookup. The requester selects the 16-bit half itself.
- Flush:
  - All valid bits clear on the next edge. The pointer is not reset.
  - Flush coincident with an IDLE AR handshake: flush has priority and the lookup is treated as a miss.
  - Flush during FETCH_ADDR or FETCH_DATA: the fill data is still returned to the requester, but the entry is written with valid=0.
- Counters saturate at 16'hFFFF and do not wrap.
- Hit on an entry with multiple matching tags: impossible by construction, because misses only fill after a failed lookup. Any matching entry may be returned.
- Reset (synchronous, rst=1 at a clk edge), including mid-transaction:
  - State returns to IDLE.
  - All valid bits clear; pointer=0; counters=0.
  - s_axil_rvalid=0, m_axil_arvalid=0, m_axil_rready=0, m_axil_araddr=0, s_axil_rdata=0.
  - s_axil_arready=0 during reset, 1 from the first cycle after.
  - A memory response arriving after reset is ignored because m_axil_rready=0.

Test Plan:
- Cold miss: read 0x0000_1002, memory returns 0xBEEF_CAFE after 3 cycles -> m_axil_araddr=0x0000_1000; s_axil_rdata=0xBEEF_CAFE; miss_count=1, hit_count=0.
- Hit: read 0x0000_1000 right after the cold miss -> no m_axil_arvalid; s_axil_rvalid one cycle after the AR handshake with 0xBEEF_CAFE; hit_count=1.
- Replacement: miss on 9 distinct words 0x0,0x4,...,0x20 with ENTRIES=8, then read 0x0 -> the ninth fill evicted entry 0; the read of 0x0 misses; miss_count=10.
- Backpressure: hold s_axil_rready=0 for 5 cycles on a hit, and m_axil_arready=0 for 4 cycles on a miss -> rdata, m_axil_araddr and both valids stay stable; no second memory read issued.
- Flush: fill 0x100, pulse flush, read 0x100 -> miss. Also pulse flush during FETCH_DATA for 0x200, then read 0x200 again -> first read returns data, second read misses.
- Reset mid-fetch: assert rst in FETCH_DATA, then assert m_axil_rvalid -> no s_axil_rvalid; counters=0; a subsequent read of the same address misses.

Source files
------------

// File: rtl/audio_sample_prefetch_cache.sv
// Fully-associative read cache for 32-bit words that hold two audio samples each.
// Round-robin fill; a hit answers in one cycle; flush and reset drop every entry.
module audio_sample_prefetch_cache #(
  parameter int ENTRIES = 8,
  parameter int PTR_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] s_axil_araddr,
  input  logic        s_axil_arvalid,
  output logic        s_axil_arready,
  output logic [31:0] s_axil_rdata,
  output logic        s_axil_rvalid,
  input  logic        s_axil_rready,
  output logic [31:0] m_axil_araddr,
  output logic        m_axil_arvalid,
  input  logic        m_axil_arready,
  input  logic [31:0] m_axil_rdata,
  input  logic        m_axil_rvalid,
  output logic        m_axil_rready,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  typedef enum logic [1:0] {IDLE, FETCH_ADDR, FETCH_DATA, RESPOND} state_e;

  state_e             state_q, state_d;
  logic [ENTRIES-1:0] vld_q, vld_d;
  logic [29:0]        tag_q  [ENTRIES];
  logic [31:0]        data_q [ENTRIES];
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [29:0]        addr_q, addr_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               flush_pend_q, flush_pend_d;
  logic [15:0]        hit_q, hit_d, miss_q, miss_d;
  logic               lookup_hit;
  logic [31:0]        hit_data;
  logic               fill_en;
  logic [1:0]         unused_lsb;

  assign unused_lsb = s_axil_araddr[1:0];

  assign s_axil_arready = (state_q == IDLE) && !rst;
  assign s_axil_rvalid  = (state_q == RESPOND);
  assign s_axil_rdata   = rdata_q;
  assign m_axil_arvalid = (state_q == FETCH_ADDR);
  assign m_axil_araddr  = {addr_q, 2'b00};
  assign m_axil_rready  = (state_q == FETCH_DATA);
  assign hit_count      = hit_q;
  assign miss_count     = miss_q;

  always_comb begin
    lookup_hit = 1'b0;
    hit_data   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (vld_q[i] && (tag_q[i] == s_axil_araddr[31:2])) begin
        lookup_hit = 1'b1;
        hit_data   = data_q[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    vld_d        = vld_q;
    ptr_d        = ptr_q;
    addr_d       = addr_q;
    rdata_d      = rdata_q;
    flush_pend_d = flush_pend_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    fill_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_axil_arvalid) begin
          flush_pend_d = 1'b0;
          // A coincident flush invalidates before the lookup can use the entry.
          if (lookup_hit && !flush) begin
            rdata_d = hit_data;
            state_d = RESPOND;
            hit_d   = (hit_q == 16'hFFFF) ? hit_q : hit_q + 16'd1;
          end else begin
            addr_d  = s_axil_araddr[31:2];
            state_d = FETCH_ADDR;
            miss_d  = (miss_q == 16'hFFFF) ? miss_q : miss_q + 16'd1;
          end
        end
      end
      FETCH_ADDR: begin
        if (flush) flush_pend_d = 1'b1;
        if (m_axil_arready) state_d = FETCH_DATA;
      end
      FETCH_DATA: begin
        if (flush) flush_pend_d = 1'b1;
        if (m_axil_rvalid) begin
          fill_en      = 1'b1;
          // Data fetched across a flush may be stale: deliver it but do not keep it.
          vld_d[ptr_q] = !(flush_pend_q || flush);
          ptr_d        = ptr_q + PTR_W'(1);
          rdata_d      = m_axil_rdata;
          state_d      = RESPOND;
        end
      end
      RESPOND: begin
        if (s_axil_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) vld_d = '0;
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[ptr_q]  <= addr_q;
      data_q[ptr_q] <= m_axil_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      vld_q        <= '0;
      ptr_q        <= '0;
      addr_q       <= '0;
      rdata_q      <= '0;
      flush_pend_q <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      vld_q        <= vld_d;
      ptr_q        <= ptr_d;
      addr_q       <= addr_d;
      rdata_q      <= rdata_d;
      flush_pend_q <= flush_pend_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

endmodule

// File: tb/tb_audio_sample_prefetch_cache.sv
// Randomized bench for audio_sample_prefetch_cache against a queue-based cache model.
module tb_audio_sample_prefetch_cache;
  localparam int ENTRIES = 8;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [31:0] s_axil_araddr, s_axil_rdata, m_axil_araddr, m_axil_rdata;
  logic        s_axil_arvalid, s_axil_arready, s_axil_rvalid, s_axil_rready;
  logic        m_axil_arvalid, m_axil_arready, m_axil_rvalid, m_axil_rready;
  logic [15:0] hit_count, miss_count;

  always #5 clk = ~clk;

  audio_sample_prefetch_cache #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: cache contents are the last ENTRIES fills in order; flush marks them stale.
  typedef struct packed {
    logic [29:0] tag;
    logic        vld;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_hits, m_misses, gen;
  bit          force_en;
  logic [31:0] force_dat;

  function automatic bit model_lookup(input logic [29:0] tag, output logic [31:0] d);
    d = '0;
    foreach (mq[i]) if (mq[i].vld && mq[i].tag == tag) begin d = mq[i].data; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic void model_fill(input logic [29:0] tag, input logic v, input logic [31:0] d);
    ent_t e;
    e.tag = tag; e.vld = v; e.data = d;
    mq.push_back(e);
    if (mq.size() > ENTRIES) void'(mq.pop_front());
  endfunction

  function automatic void model_flush();
    foreach (mq[i]) mq[i].vld = 1'b0;
    gen++;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ (32'h9E37_79B9 * gen) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] sat(input int unsigned v);
    return (v > 65535) ? 32'h0000_FFFF : v;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_hits"}, 32'(hit_count), sat(m_hits));
    check({tag, "_misses"}, 32'(miss_count), sat(m_misses));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_arready", 32'(s_axil_arready), 32'd0);
    check("rst_rvalid", 32'(s_axil_rvalid), 32'd0);
    check("rst_m_arvalid", 32'(m_axil_arvalid), 32'd0);
    check("rst_m_rready", 32'(m_axil_rready), 32'd0);
    check("rst_m_araddr", m_axil_araddr, 32'd0);
    check("rst_rdata", s_axil_rdata, 32'd0);
    rst = 1'b0;
    mq.delete();
    m_hits = 0;
    m_misses = 0;
    @(negedge clk);
    check("post_rst_arready", 32'(s_axil_arready), 32'd1);
    check_counters("post_rst");
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_flush();
  endtask

  // fmode: 0 none, 1 flush on the AR handshake, 2 flush while waiting for memory data.
  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                         input int rr_dly, input int fmode);
    logic [31:0] exp_d, mdat;
    bit          hit, fill_vld;
    if (fmode == 2 && r_dly < 1) r_dly = 1;
    @(negedge clk);
    check("arready_idle", 32'(s_axil_arready), 32'd1);
    if (fmode == 1) model_flush();
    hit = model_lookup(addr[31:2], exp_d);
    s_axil_araddr  = addr;
    s_axil_arvalid = 1'b1;
    flush          = (fmode == 1);
    @(negedge clk);
    s_axil_arvalid = 1'b0;
    flush          = 1'b0;
    s_axil_araddr  = $urandom;
    check("arready_busy", 32'(s_axil_arready), 32'd0);
    if (hit) begin
      m_hits++;
      check("hit_rvalid", 32'(s_axil_rvalid), 32'd1);
      check("hit_no_mem", 32'(m_axil_arvalid), 32'd0);
      check("hit_rdata", s_axil_rdata, exp_d);
    end else begin
      m_misses++;
      check("miss_rvalid", 32'(s_axil_rvalid), 32'd0);
      for (int i = 0; i <= ar_dly; i++) begin
        check("m_arvalid", 32'(m_axil_arvalid), 32'd1);
        check("m_araddr", m_axil_araddr, {addr[31:2], 2'b00});
        if (i == ar_dly) m_axil_arready = 1'b1;
        @(negedge clk);
        m_axil_arready = 1'b0;
      end
      check("m_arvalid_drop", 32'(m_axil_arvalid), 32'd0);
      check("m_rready", 32'(m_axil_rready), 32'd1);
      fill_vld = 1'b1;
      for (int i = 0; i < r_dly; i++) begin
        if (fmode == 2 && i == 0) flush = 1'b1;
        @(negedge clk);
        if (flush) begin
          flush = 1'b0;
          model_flush();
          fill_vld = 1'b0;
        end
        check("m_rready_hold", 32'(m_axil_rready), 32'd1);
        check("wait_no_rvalid", 32'(s_axil_rvalid), 32'd0);
        check("wait_no_2nd_ar", 32'(m_axil_arvalid), 32'd0);
      end
      mdat = force_en ? force_dat : mem_word(addr);
      m_axil_rdata  = mdat;
      m_axil_rvalid = 1'b1;
      @(negedge clk);
      m_axil_rvalid = 1'b0;
      m_axil_rdata  = $urandom;
      check("fill_rvalid", 32'(s_axil_rvalid), 32'd1);
      check("fill_rdata", s_axil_rdata, mdat);
      check("fill_rready_drop", 32'(m_axil_rready), 32'd0);
      model_fill(addr[31:2], fill_vld, mdat);
      exp_d = mdat;
    end
    for (int i = 0; i < rr_dly; i++) begin
      @(negedge clk);
      check("rvalid_hold", 32'(s_axil_rvalid), 32'd1);
      check("rdata_hold", s_axil_rdata, exp_d);
      check("hold_no_mem", 32'(m_axil_arvalid), 32'd0);
    end
    s_axil_rready = 1'b1;
    @(negedge clk);
    s_axil_rready = 1'b0;
    check("rvalid_drop", 32'(s_axil_rvalid), 32'd0);
    check_counters("txn");
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    s_axil_araddr = '0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b0;
    m_axil_arready = 1'b0; m_axil_rdata = '0; m_axil_rvalid = 1'b0;
    force_en = 1'b0; force_dat = '0; gen = 0;
    do_reset();

    // Cold miss then hit on the other half of the same word.
    force_en = 1'b1; force_dat = 32'hBEEF_CAFE;
    do_read(32'h0000_1002, 0, 3, 0, 0);
    force_en = 1'b0;
    check("cold_miss_count", 32'(miss_count), 32'd1);
    do_read(32'h0000_1000, 0, 0, 0, 0);
    check("hit_count_one", 32'(hit_count), 32'd1);

    // Nine fills into eight entries evict the first one.
    do_reset();
    for (int k = 0; k < 9; k++) do_read(32'(k * 4), 0, 1, 0, 0);
    do_read(32'h0, 0, 1, 0, 0);
    check("evict_miss_count", 32'(miss_count), 32'd10);

    // Backpressure on both sides.
    do_read(32'h20, 0, 0, 5, 0);
    do_read(32'h300, 4, 2, 3, 0);

    // Flush between reads and during a fill.
    do_read(32'h100, 0, 1, 0, 0);
    do_flush();
    do_read(32'h100, 0, 1, 0, 0);
    do_read(32'h200, 0, 2, 0, 2);
    do_read(32'h200, 0, 1, 0, 0);
    do_read(32'h204, 0, 1, 0, 1);

    // Reset while waiting for memory data; the late response must be ignored.
    @(negedge clk);
    s_axil_araddr = 32'h400; s_axil_arvalid = 1'b1; m_axil_arready = 1'b1;
    @(negedge clk);
    s_axil_arvalid = 1'b0;
    @(negedge clk);
    m_axil_arready = 1'b0;
    check("rf_in_fetch_data", 32'(m_axil_rready), 32'd1);
    do_reset();
    m_axil_rvalid = 1'b1; m_axil_rdata = 32'h1234_5678;
    @(negedge clk);
    m_axil_rvalid = 1'b0;
    check("rf_no_rvalid", 32'(s_axil_rvalid), 32'd0);
    @(negedge clk);
    check("rf_no_rvalid2", 32'(s_axil_rvalid), 32'd0);
    check_counters("rf");
    do_read(32'h400, 0, 1, 0, 0);
    check("rf_reread_miss", 32'(miss_count), 32'd1);

    // Random traffic over a small working set so hits, evictions and flushes interleave.
    for (int n = 0; n < 300; n++) begin
      int fm;
      fm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      if ($urandom_range(0, 19) == 0) do_flush();
      do_read((32'($urandom_range(0, 11)) << 2) | 32'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), fm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end
endmodule
